fnd_display_ctrl: RTL and testbench

- Consumer end of the 14-bit FND count bus driven by the 0–9999 counter.
- Takes the binary count, converts it to four BCD digits with a sequential double-dabble engine, and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Sits between the counter and the board FND pins.

---
 rtl/fnd_pkg.sv | 36 +++
 rtl/fnd_display_ctrl_bin2bcd_seq.sv | 103 ++++++++++
 rtl/fnd_display_ctrl.sv | 103 ++++++++++
 tb/tb_fnd_display_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND display path: converter states,
// value/BCD widths and the active-low 7-segment font table.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam int VALUE_W = 14;
    localparam int BCD_W   = 16;
    localparam int SHIFT_W = BCD_W + VALUE_W;

    localparam logic [VALUE_W-1:0] FND_MAX = 14'd9999;

    // Entries 0..9 are the decimal glyphs {dp,g,f,e,d,c,b,a}, entry 10 is blank.
    localparam logic [7:0] FONT_TABLE [0:10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
        8'hFF
    };

    function automatic logic [7:0] font_of(input logic [3:0] nib, input logic blank);
        logic [7:0] seg;
        if (blank) begin
            seg = FONT_TABLE[10];
        end else if (nib > 4'd9) begin
            seg = FONT_TABLE[10];
        end else begin
            seg = FONT_TABLE[nib];
        end
        return seg;
    endfunction

endpackage

// File: rtl/fnd_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, 14 shift cycles,
// input clamped to 9999 with an overflow flag carried alongside the result.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [VALUE_W-1:0] i_value,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd,
    output logic               o_ovf
);

    conv_state_e        state_r;
    conv_state_e        state_next_s;
    logic [SHIFT_W-1:0] shift_r;
    logic [SHIFT_W-1:0] adj_s;
    logic [3:0]         bit_cnt_r;
    logic               ovf_pend_r;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = i_start ? SHIFT : IDLE;
            SHIFT:   state_next_s = (bit_cnt_r == 4'd13) ? DONE : SHIFT;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that would overflow after the shift
    always_comb begin
        adj_s = shift_r;
        for (int i = 0; i < 4; i++) begin
            if (shift_r[VALUE_W + 4*i +: 4] >= 4'd5) begin
                adj_s[VALUE_W + 4*i +: 4] = shift_r[VALUE_W + 4*i +: 4] + 4'd3;
            end else begin
                adj_s[VALUE_W + 4*i +: 4] = shift_r[VALUE_W + 4*i +: 4];
            end
        end
    end

    // Datapath: capture/clamp in IDLE, shift in SHIFT, hold otherwise
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_r    <= {SHIFT_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            ovf_pend_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 4'd0;
                    if (i_start) begin
                        if (i_value > FND_MAX) begin
                            shift_r    <= {{BCD_W{1'b0}}, FND_MAX};
                            ovf_pend_r <= 1'b1;
                        end else begin
                            shift_r    <= {{BCD_W{1'b0}}, i_value};
                            ovf_pend_r <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    shift_r   <= {adj_s[SHIFT_W-2:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_r)
            SHIFT:   o_busy = 1'b1;
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: o_busy = 1'b0;
        endcase
    end

    assign o_bcd = shift_r[SHIFT_W-1 -: BCD_W];
    assign o_ovf = ovf_pend_r;

endmodule

// File: rtl/fnd_display_ctrl.sv
// 4-digit common-anode FND driver: free-running binary-to-BCD conversion,
// leading-zero blanking and a registered digit scan.
module fnd_display_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [VALUE_W-1:0] i_value,
    output logic [3:0]         o_fnd_com,
    output logic [7:0]         o_fnd_font,
    output logic               o_ovf,
    output logic               o_busy
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             conv_done_s;
    logic [BCD_W-1:0] conv_bcd_s;
    logic             conv_ovf_s;
    logic [BCD_W-1:0] bcd_r;
    logic             ovf_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic             tick_s;
    logic [1:0]       digit_idx_r;
    logic [3:0]       blank_s;
    logic [3:0]       digit_s;
    logic [3:0]       com_r;
    logic [7:0]       font_r;

    bin2bcd_seq u_bin2bcd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (1'b1),
        .i_value   (i_value),
        .o_busy    (o_busy),
        .o_done    (conv_done_s),
        .o_bcd     (conv_bcd_s),
        .o_ovf     (conv_ovf_s)
    );

    // Result snapshot: only a finished conversion ever reaches the display
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bcd_r <= {BCD_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (conv_done_s) begin
            bcd_r <= conv_bcd_s;
            ovf_r <= conv_ovf_s;
        end else begin
            bcd_r <= bcd_r;
            ovf_r <= ovf_r;
        end
    end

    assign tick_s = (tick_cnt_r == CNT_W'(SCAN_DIV - 1));

    // Scan prescaler and digit index
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tick_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= 2'd0;
        end else if (tick_s) begin
            tick_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= digit_idx_r + 2'd1;
        end else begin
            tick_cnt_r  <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            digit_idx_r <= digit_idx_r;
        end
    end

    // A digit above the units is blank when it and everything above it is zero
    always_comb begin
        blank_s = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            if (BLANK_LZ && ((bcd_r >> (4*k)) == {BCD_W{1'b0}})) begin
                blank_s[k] = 1'b1;
            end else begin
                blank_s[k] = 1'b0;
            end
        end
    end

    assign digit_s = bcd_r[{digit_idx_r, 2'b00} +: 4];

    // Common and segment lines come from the same index/snapshot, so they switch together
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            com_r  <= 4'b1110;
            font_r <= 8'hC0;
        end else begin
            com_r  <= ~(4'b0001 << digit_idx_r);
            font_r <= font_of(digit_s, blank_s[digit_idx_r]);
        end
    end

    assign o_fnd_com  = com_r;
    assign o_fnd_font = font_r;
    assign o_ovf      = ovf_r;

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// Randomized self-checking bench for fnd_display_ctrl against a decimal
// arithmetic model of what each digit position should show.
module tb_fnd_display_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value;

    logic [3:0]  com_a,  com_b;
    logic [7:0]  font_a, font_b;
    logic        ovf_a,  ovf_b;
    logic        busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value),
        .o_fnd_com(com_a), .o_fnd_font(font_a), .o_ovf(ovf_a), .o_busy(busy_a)
    );

    fnd_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nz (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value),
        .o_fnd_com(com_b), .o_fnd_font(font_b), .o_ovf(ovf_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Glyph for decimal position k of v; positions above the leading digit are blank if blz
    function automatic int exp_font(input int v, input int k, input bit blz);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (blz && k > 0 && v < p) return 8'hFF;
        return int'(seg_tab[(v / p) % 10]);
    endfunction

    function automatic int com_digit(input logic [3:0] com);
        case (com)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic disp_check(input string tag, input int v);
        int ka, kb;
        ka = com_digit(com_a);
        kb = com_digit(com_b);
        check({tag, "_com"}, (ka >= 0) ? 1 : 0, 1);
        check({tag, "_com_nz"}, (kb >= 0) ? 1 : 0, 1);
        if (ka >= 0) check({tag, "_font"}, font_a, exp_font(v, ka, 1'b1));
        if (kb >= 0) check({tag, "_font_nz"}, font_b, exp_font(v, kb, 1'b0));
    endtask

    // One full scan round: every digit, correct pairing, ascending order
    task automatic scan_check(input string tag, input int v, input bit ovf);
        int prev = -1;
        int k;
        logic [3:0] seen = 4'b0000;
        repeat (4 * SCAN_DIV) begin
            @(negedge clk);
            disp_check(tag, v);
            k = com_digit(com_a);
            if (k >= 0) begin
                if (prev >= 0 && k != prev) check({tag, "_order"}, k, (prev + 1) % 4);
                seen[k] = 1'b1;
                prev = k;
            end
        end
        check({tag, "_seen"}, seen, 4'hF);
        check({tag, "_ovf"}, ovf_a, ovf);
    endtask

    task automatic settle(input int v);
        value = 14'(v);
        repeat (40) @(negedge clk);
    endtask

    task automatic sync_idle(input string tag);
        int n = 0;
        while (busy_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_seen"}, busy_a, 1'b0);
    endtask

    initial begin
        int cnt;
        int v;
        int v_cap;

        rst_n = 1'b0;
        value = 14'd1234;
        repeat (3) @(negedge clk);
        check("rst_com", com_a, 4'b1110);
        check("rst_font", font_a, 8'hC0);
        check("rst_font_nz", font_b, 8'hC0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);

        // First conversion after release: latency and busy length
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_first", busy_a, 1'b1);
        cnt = 0;
        while (busy_a && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_len", cnt, 15);
        disp_check("pre1234", 0);
        @(negedge clk);
        disp_check("post1234", 1234);
        scan_check("v1234", 1234, 1'b0);

        settle(7);     scan_check("v7", 7, 1'b0);
        settle(0);     scan_check("v0", 0, 1'b0);
        settle(9999);  scan_check("v9999", 9999, 1'b0);
        settle(12000); scan_check("v12000", 9999, 1'b1);

        // Overflow must clear within 32 cycles of a legal value
        value = 14'd5;
        cnt = 0;
        while (ovf_a && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("ovf_clear_time", (cnt <= 32) ? 1 : 0, 1);
        check("ovf_clear", ovf_a, 1'b0);
        @(negedge clk);
        scan_check("v5", 5, 1'b0);

        // Input churn during SHIFT must not leak into the result
        sync_idle("churn");
        v_cap = int'($urandom_range(0, 9999));
        value = 14'(v_cap);
        @(negedge clk);
        cnt = 0;
        while (busy_a && cnt < 40) begin
            cnt++;
            disp_check("hold5", 5);
            value = 14'($urandom_range(0, 16383));
            @(negedge clk);
        end
        check("busy_len_churn", cnt, 15);
        value = 14'(v_cap);
        disp_check("pre_cap", 5);
        @(negedge clk);
        scan_check("captured", v_cap, 1'b0);

        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 16383));
            settle(v);
            scan_check("rnd", (v > 9999) ? 9999 : v, (v > 9999) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset at SHIFT bit 7
        settle(12000);
        sync_idle("rst_mid");
        @(negedge clk);
        check("rst_mid_busy", busy_a, 1'b1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_com", com_a, 4'b1110);
        check("arst_font", font_a, 8'hC0);
        check("arst_ovf", ovf_a, 1'b0);
        check("arst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(4321);
        scan_check("post_rst", 4321, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
